display_ctrl: RTL and testbench



---
 rtl/display_ctrl.sv | 153 +++++++++++++++
 tb/tb_display_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/display_ctrl.sv
// Registered front-panel driver: N-digit seven-segment bank plus RGB LED,
// with timed OPEN message (done pulse) and blinking CALL 911 alarm.

module ssdec (
  input  logic [3:0] code,
  input  logic       enable,
  output logic [7:0] segs
);
  always_comb begin
    segs = '0;
    if (enable) begin
      case (code)
        4'h0: segs = 8'h3F;
        4'h1: segs = 8'h06;
        4'h2: segs = 8'h5B;
        4'h3: segs = 8'h4F;
        4'h4: segs = 8'h66;
        4'h5: segs = 8'h6D;
        4'h6: segs = 8'h7D;
        4'h7: segs = 8'h07;
        4'h8: segs = 8'h7F;
        4'h9: segs = 8'h6F;
        4'hA: segs = 8'h77;
        4'hB: segs = 8'h7C;
        4'hC: segs = 8'h39;
        4'hD: segs = 8'h5E;
        4'hE: segs = 8'h79;
        default: segs = 8'h71;
      endcase
    end
  end
endmodule

module display_ctrl #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned BLINK_DIV  = 50,
  parameter int unsigned OPEN_HOLD  = 200,
  localparam int unsigned CW        = $clog2(NUM_DIGITS + 1)
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic [1:0]              mode,
  input  logic [CW-1:0]           entry_cnt,
  input  logic [4*NUM_DIGITS-1:0] seq,
  output logic [8*NUM_DIGITS-1:0] ss,
  output logic                    red,
  output logic                    green,
  output logic                    blue,
  output logic                    open_done
);
  typedef enum logic [1:0] {
    S_ENTRY = 2'd0,
    S_OPEN  = 2'd1,
    S_ALARM = 2'd2,
    S_INIT  = 2'd3
  } state_t;

  localparam int unsigned HW = $clog2(OPEN_HOLD + 1);
  localparam int unsigned BW = $clog2(BLINK_DIV + 1);
  localparam logic [7:0] DASH = 8'h80;
  // Texts padded to 16 characters, rightmost character in the low byte.
  localparam logic [127:0] OPEN_TXT = 128'h3F737954;
  localparam logic [127:0] CALL_TXT = 128'h39773838006F0606;

  state_t              st, st_nx;
  logic [HW-1:0]       hold_cnt, hold_nx;
  logic [BW-1:0]       blink_cnt, blink_nx;
  logic                phase, phase_nx;
  logic                chg, done_nx, green_nx, blue_nx;
  logic [8*NUM_DIGITS-1:0] ss_nx;
  logic [7:0]          dec [NUM_DIGITS];

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    ssdec u_dec (
      .code  (seq[4*g +: 4]),
      .enable(1'b1),
      .segs  (dec[g])
    );
  end

  // Outputs are computed from the post-edge counter values so every
  // input change is visible exactly one cycle later.
  always_comb begin
    st_nx    = state_t'(mode);
    chg      = (st_nx != st);
    hold_nx  = '0;
    blink_nx = '0;
    phase_nx = 1'b0;
    done_nx  = 1'b0;
    green_nx = 1'b0;
    blue_nx  = 1'b0;
    ss_nx    = '0;
    case (st_nx)
      S_INIT: begin
        for (int unsigned i = 0; i < NUM_DIGITS; i++) ss_nx[8*i +: 8] = dec[i];
      end
      S_ENTRY: begin
        for (int unsigned i = 0; i < NUM_DIGITS; i++)
          ss_nx[8*i +: 8] = (i < 32'(entry_cnt)) ? dec[i] : DASH;
      end
      S_OPEN: begin
        green_nx = 1'b1;
        if (chg) begin
          done_nx = (OPEN_HOLD == 1);
        end else if (hold_cnt != HW'(OPEN_HOLD - 1)) begin
          hold_nx = hold_cnt + HW'(1);
          done_nx = (hold_nx == HW'(OPEN_HOLD - 1));
        end else begin
          hold_nx = hold_cnt;
        end
        for (int unsigned i = 0; i < NUM_DIGITS; i++) ss_nx[8*i +: 8] = OPEN_TXT[8*i +: 8];
      end
      default: begin
        if (!chg) begin
          if (blink_cnt == BW'(BLINK_DIV - 1)) begin
            blink_nx = '0;
            phase_nx = ~phase;
          end else begin
            blink_nx = blink_cnt + BW'(1);
            phase_nx = phase;
          end
        end
        blue_nx = phase_nx;
        if (phase_nx)
          for (int unsigned i = 0; i < NUM_DIGITS; i++) ss_nx[8*i +: 8] = CALL_TXT[8*i +: 8];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      st        <= S_INIT;
      hold_cnt  <= '0;
      blink_cnt <= '0;
      phase     <= 1'b0;
      ss        <= '0;
      red       <= 1'b0;
      green     <= 1'b0;
      blue      <= 1'b0;
      open_done <= 1'b0;
    end else begin
      st        <= st_nx;
      hold_cnt  <= hold_nx;
      blink_cnt <= blink_nx;
      phase     <= phase_nx;
      ss        <= ss_nx;
      red       <= 1'b0;
      green     <= green_nx;
      blue      <= blue_nx;
      open_done <= done_nx;
    end
  end
endmodule

// File: tb/tb_display_ctrl.sv
// Scoreboard bench for display_ctrl: driver pushes model expectations,
// monitor pops and compares one cycle after each edge.

module tb_display_ctrl;
  localparam int unsigned ND = 8;
  localparam int unsigned BD = 4;
  localparam int unsigned OH = 6;

  logic          clk = 1'b0;
  logic          n_rst;
  logic [1:0]    mode;
  logic [3:0]    entry_cnt;
  logic [31:0]   seq;
  logic [63:0]   ss;
  logic          red, green, blue, open_done;

  display_ctrl #(.NUM_DIGITS(ND), .BLINK_DIV(BD), .OPEN_HOLD(OH)) dut (
    .clk(clk), .n_rst(n_rst), .mode(mode), .entry_cnt(entry_cnt), .seq(seq),
    .ss(ss), .red(red), .green(green), .blue(blue), .open_done(open_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] ss;
    logic [3:0]  leds; // red, green, blue, open_done
  } exp_t;

  exp_t expq[$];
  int checks = 0;
  int failures = 0;

  logic [7:0] dec_t [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                             8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
  // Messages written left to right as read on the panel.
  logic [7:0] open_l [4] = '{8'h3F, 8'h73, 8'h79, 8'h54};
  logic [7:0] call_l [8] = '{8'h39, 8'h77, 8'h38, 8'h38, 8'h00, 8'h6F, 8'h06, 8'h06};

  // Reference model: time spent in the current mode determines everything.
  int unsigned k = 0;
  logic [1:0]  prev = 2'd3;

  task automatic drive(input logic r, input logic [1:0] m, input logic [3:0] c,
                       input logic [31:0] s);
    exp_t e;
    int unsigned n;
    @(negedge clk);
    n_rst = r; mode = m; entry_cnt = c; seq = s;
    e = '0;
    if (!r) begin
      prev = 2'd3;
      k = 0;
    end else begin
      if (m == prev) k++;
      else k = 0;
      prev = m;
      case (m)
        2'd3: for (int d = 0; d < 8; d++) e.ss[8*d +: 8] = dec_t[s[4*d +: 4]];
        2'd0: begin
          n = (c > 8) ? 8 : c;
          for (int d = 0; d < 8; d++)
            e.ss[8*d +: 8] = (d < n) ? dec_t[s[4*d +: 4]] : 8'h80;
        end
        2'd1: begin
          e.leds[2] = 1'b1;
          e.leds[0] = (k == OH - 1);
          for (int d = 0; d < 4; d++) e.ss[8*d +: 8] = open_l[3-d];
        end
        default: begin
          if (((k / BD) % 2) == 1) begin
            e.leds[1] = 1'b1;
            for (int d = 0; d < 8; d++) e.ss[8*d +: 8] = call_l[7-d];
          end
        end
      endcase
    end
    expq.push_back(e);
  endtask

  task automatic hold(input logic [1:0] m, input logic [3:0] c, input logic [31:0] s,
                      input int cycles);
    for (int i = 0; i < cycles; i++) drive(1'b1, m, c, s);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() != 0) begin
        e = expq.pop_front();
        checks++;
        if (ss !== e.ss) begin
          failures++;
          $display("FAIL ss t=%0t actual=%h required=%h", $time, ss, e.ss);
        end
        checks++;
        if ({red, green, blue, open_done} !== e.leds) begin
          failures++;
          $display("FAIL leds(r,g,b,done) t=%0t actual=%b required=%b", $time,
                   {red, green, blue, open_done}, e.leds);
        end
      end
    end
  end

  initial begin
    n_rst = 1'b0; mode = 2'd0; entry_cnt = '0; seq = '0;
    // 1: reset then INIT view
    drive(1'b0, 2'($urandom), 4'($urandom), $urandom);
    drive(1'b0, 2'($urandom), 4'($urandom), $urandom);
    hold(2'd3, 4'd0, 32'h1234_5678, 3);
    // 2: ENTRY with partial, empty and saturated count
    hold(2'd0, 4'd0, 32'h0000_0042, 2);
    hold(2'd0, 4'd2, 32'h0000_0042, 2);
    hold(2'd0, 4'd9, 32'h0000_0042, 2);
    // 3: OPEN hold and single pulse
    hold(2'd1, 4'd0, 32'h0, 10);
    // 4: ALARM blinking, then leave
    hold(2'd2, 4'd0, 32'h0, 16);
    hold(2'd0, 4'd3, 32'h8765_4321, 2);
    // 5: reset mid-OPEN, then re-enter
    hold(2'd1, 4'd0, 32'h0, 5);
    drive(1'b0, 2'd1, 4'd0, 32'h0);
    hold(2'd1, 4'd0, 32'h0, 8);
    // 6: leave OPEN on the expiry edge
    hold(2'd3, 4'd0, 32'h0, 1);
    hold(2'd1, 4'd0, 32'h0, 5);
    hold(2'd0, 4'd1, 32'hABCD_EF01, 3);
    // Random segments
    for (int seg = 0; seg < 60; seg++) begin
      logic [1:0] m;
      int len;
      m = 2'($urandom);
      len = $urandom_range(1, 14);
      for (int i = 0; i < len; i++)
        drive(($urandom_range(0, 59) != 0), m, 4'($urandom), $urandom);
    end
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (expq.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d pending required=0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
